// File: rtl/riscv_pkg.sv
// Shared types for the core front end.
// Opcode map, reset address and fetch FSM states.
package riscv_pkg;

   localparam int unsigned ILEN = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [6:0] {
      RType    = 7'b0110011,
      Load     = 7'b0000011,
      IType    = 7'b0010011,
      SType    = 7'b0100011,
      BType    = 7'b1100011,
      AddUpp   = 7'b0010111,
      LoadUpp  = 7'b0110111,
      JumpImm  = 7'b1100111,
      JumpLink = 7'b1101111
   } opcode_e;

   typedef enum logic {
      RUN  = 1'b0,
      DROP = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with clear.
// Head reads as zero while empty.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   // Pointer and occupancy bookkeeping; clear wins over push/pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, memory requests, buffer.
// Redirects flush and discard stale responses.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH      = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   =
      ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [ILEN-1:0]       imem_rdata_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [ILEN-1:0]       instr_o,
   output logic [6:0]            opcode_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   // Stale responses can pile up over back-to-back
   // redirects with a slow memory, so keep headroom.
   localparam int unsigned DW = 16;
   localparam int unsigned HW = ADDR_WIDTH + ILEN;

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         out_q, out_d;
   logic [DW-1:0]         drop_q, drop_d;

   logic            grant, pop, rv_take, rv_drop;
   logic [CW:0]     credit;
   logic [HW-1:0]   ib_head;
   logic [CW-1:0]   ib_count, aq_count;
   logic            ib_empty, ib_full, aq_empty, aq_full;
   logic [ADDR_WIDTH-1:0] aq_head;
   logic            unused_ok;

   assign rv_drop = imem_rvalid_i && (state_q == DROP);
   assign rv_take = imem_rvalid_i && (state_q == RUN)
                    && (out_q != '0);

   assign valid_o = !ib_empty && !redirect_i;
   assign pop     = valid_o && ready_i;

   // A slot popped this cycle is already free for a new request.
   assign credit = {1'b0, ib_count} + {1'b0, out_q}
                   - (CW+1)'(pop);

   assign imem_req_o  = rst_ni && !redirect_i
                        && (credit < (CW+1)'(DEPTH));
   assign imem_addr_o = pc_q;
   assign grant       = imem_req_o && imem_gnt_i;

   assign pc_o     = ib_head[HW-1 -: ADDR_WIDTH];
   assign instr_o  = ib_head[ILEN-1:0];
   assign opcode_o = instr_o[6:0];

   assign unused_ok = ^{aq_count, aq_empty, aq_full,
                        ib_full, redirect_pc_i[1:0]};

   fetch_fifo #(.WIDTH(HW), .DEPTH(DEPTH)) u_ibuf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rv_take && !redirect_i),
      .pop_i   (pop),
      .clear_i (redirect_i),
      .wdata_i ({aq_head, imem_rdata_i}),
      .rdata_o (ib_head),
      .count_o (ib_count),
      .empty_o (ib_empty),
      .full_o  (ib_full)
   );

   fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_addrq (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (grant),
      .pop_i   (rv_take),
      .clear_i (redirect_i),
      .wdata_i (pc_q),
      .rdata_o (aq_head),
      .count_o (aq_count),
      .empty_o (aq_empty),
      .full_o  (aq_full)
   );

   // Next PC, in-flight/stale counters and RUN/DROP state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      drop_d  = drop_q;
      if (redirect_i) begin
         pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
         out_d   = '0;
         drop_d  = DW'(out_q) + drop_q
                   - DW'(rv_take || rv_drop);
         state_d = (drop_d != '0) ? DROP : RUN;
      end else begin
         if (grant) pc_d = pc_q + ADDR_WIDTH'(4);
         out_d  = out_q + CW'(grant) - CW'(rv_take);
         drop_d = drop_q - DW'(rv_drop);
         unique case (state_q)
            RUN:  state_d = RUN;
            DROP: if (rv_drop && drop_q == DW'(1))
                     state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // State registers; reset abandons every in-flight fetch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   // A response with nothing in flight is a memory protocol error.
   a_rvalid_expected: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      imem_rvalid_i |-> (out_q != '0 || drop_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table,
// directed corner cases and random traffic.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] instr_o;
   logic [6:0]  opcode_o;
   logic [31:0] pc_o;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [6:0]  w_opc;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq [$];
   logic [31:0] xq [$];
   logic [31:0] exp_pc;
   int          xfers, grants, valids;

   logic        o_req, o_valid, o_wreq;
   logic [31:0] o_addr, o_pc, o_waddr;
   logic [6:0]  o_opc;
   logic [7:0]  o_out;
   fetch_state_e o_state;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [6:0]  opc;
      logic        wreq;
      logic [31:0] waddr;
   } vec_t;
   vec_t vt [6];

   always #5 clk_i = ~clk_i;

   instr_fetch_unit u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instr_o       (instr_o),
      .opcode_o      (opcode_o),
      .pc_o          (pc_o)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_req_o    (w_req),
      .imem_addr_o   (w_addr),
      .imem_gnt_i    (1'b1),
      .imem_rvalid_i (1'b0),
      .imem_rdata_i  (32'h0),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'h0),
      .valid_o       (w_valid),
      .ready_i       (1'b0),
      .instr_o       (w_instr),
      .opcode_o      (w_opc),
      .pc_o          (w_pc)
   );

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // One clock: drive at negedge, observe, model the edge.
   task automatic cycle(input logic gnt,
                        input int unsigned rv_pct,
                        input logic rdr,
                        input logic [31:0] rpc,
                        input logic rdy);
      logic [31:0] e;
      imem_gnt_i    = gnt;
      redirect_i    = rdr;
      redirect_pc_i = rpc;
      ready_i       = rdy;
      if (mq.size() != 0 && $urandom_range(99) < rv_pct) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mq[0] | 32'h13;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
      #1;
      o_req   = imem_req_o;
      o_addr  = imem_addr_o;
      o_valid = valid_o;
      o_pc    = pc_o;
      o_opc   = opcode_o;
      o_wreq  = w_req;
      o_waddr = w_addr;
      o_out   = 8'(u_dut.out_q);
      o_state = u_dut.state_q;
      if (imem_rvalid_i) void'(mq.pop_front());
      if (imem_req_o && imem_gnt_i) begin
         mq.push_back(imem_addr_o);
         grants++;
      end
      if (rdr) chk("redirect_blocks", {valid_o, imem_req_o}, 2'b00);
      if (valid_o) begin
         valids++;
         e = exp_pc | 32'h13;
         chk("head_pc", pc_o, exp_pc);
         chk("head_instr", instr_o, e);
         chk("head_opcode", opcode_o, e[6:0]);
         if (ready_i) begin
            xfers++;
            xq.push_back(pc_o);
            exp_pc = exp_pc + 32'd4;
         end
      end
      if (rdr) exp_pc = {rpc[31:2], 2'b00};
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 32'h00, 1'b0, 32'h0, 7'h00, 1'b1, 32'hFFFF_FFFC};
      vt[1] = '{1'b1, 32'h04, 1'b0, 32'h0, 7'h00, 1'b1, 32'h0};
      vt[2] = '{1'b1, 32'h08, 1'b1, 32'h0, 7'h13, 1'b0, 32'h4};
      vt[3] = '{1'b1, 32'h0C, 1'b1, 32'h4, 7'h17, 1'b0, 32'h4};
      vt[4] = '{1'b1, 32'h10, 1'b1, 32'h8, 7'h1B, 1'b0, 32'h4};
      vt[5] = '{1'b1, 32'h14, 1'b1, 32'hC, 7'h1F, 1'b0, 32'h4};

      rst_ni = 1'b0;
      imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
      redirect_i = 0; redirect_pc_i = 0; ready_i = 0;
      exp_pc = 32'h0;
      xfers = 0; grants = 0; valids = 0;
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_req", imem_req_o, 0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_opcode", opcode_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
      chk("rst_wrap_out", {w_valid, w_instr, w_pc, w_opc}, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
         chk("tbl_req", o_req, vt[i].req);
         chk("tbl_addr", o_addr, vt[i].addr);
         chk("tbl_valid", o_valid, vt[i].valid);
         chk("tbl_pc", o_pc, vt[i].pc);
         chk("tbl_opcode", o_opc, vt[i].opc);
         chk("tbl_wrap_req", o_wreq, vt[i].wreq);
         chk("tbl_wrap_addr", o_waddr, vt[i].waddr);
      end

      valids = 0;
      repeat (10) cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
      chk("throughput", valids, 10);

      repeat (3) cycle(1'b1, 0, 1'b0, 32'h0, 1'b1);
      chk("pre_rst_outstanding", o_out, 2);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_req", imem_req_o, 0);
      chk("arst_addr", imem_addr_o, 32'h0);
      chk("arst_valid", valid_o, 0);
      chk("arst_out", {instr_o, opcode_o, pc_o}, 0);
      mq.delete();
      exp_pc = 32'h0;
      imem_gnt_i = 0; imem_rvalid_i = 0;
      redirect_i = 0; ready_i = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      grants = 0;
      cycle(1'b1, 100, 1'b0, 32'h0, 1'b0);
      chk("restart_req", o_req, 1);
      chk("restart_addr", o_addr, 32'h0);
      repeat (9) cycle(1'b1, 100, 1'b0, 32'h0, 1'b0);
      chk("bp_grants", grants, 2);
      chk("bp_req_low", o_req, 0);
      chk("bp_head_pc", o_pc, 32'h0);
      xfers = 0;
      repeat (10) cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
      chk("bp_release_xfers", xfers, 10);

      repeat (3) cycle(1'b1, 0, 1'b0, 32'h0, 1'b1);
      chk("rd_outstanding", o_out, 2);
      cycle(1'b1, 0, 1'b1, 32'h103, 1'b1);
      xq.delete();
      cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
      chk("rd_state_drop", o_state, DROP);
      chk("rd_req_next", o_req, 1);
      chk("rd_addr_next", o_addr, 32'h100);
      repeat (8) cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
      chk("rd_first_pc", xq.size() > 0 ? xq[0] : 32'hDEAD, 32'h100);
      chk("rd_state_run", o_state, RUN);

      chk("rdx_valid_before", o_valid, 1);
      cycle(1'b1, 100, 1'b1, 32'h200, 1'b1);
      xq.delete();
      repeat (8) cycle(1'b1, 100, 1'b0, 32'h0, 1'b1);
      chk("rdx_first_pc", xq.size() > 0 ? xq[0] : 32'hDEAD, 32'h200);

      xfers = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(99) < 70, 60,
               $urandom_range(99) < 3, $urandom,
               $urandom_range(99) < 70);
      end
      chk("rand_progress", xfers > 100, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
